// File: rtl/generic_lfsr_tpg.sv
// Galois LFSR test pattern generator driving a MISR compactor; pattern_out is registered, valid/done/restart are same-cycle.
// Hold stalls pattern emission in RUN; waits up to SIG_TIMEOUT cycles for compactor done. Optional macro: TPG_SEED_LOAD_EN (seed_in port).
module generic_lfsr_tpg #(
    parameter int          N            = 32,
    parameter int          NUM_PATTERNS = 32,
    parameter logic [N-1:0] SEED        = {{(N-1){1'b0}}, 1'b1},
    parameter int          SIG_TIMEOUT  = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         hold,
    input  logic [N-1:0] coeff,
`ifdef TPG_SEED_LOAD_EN
    input  logic [N-1:0] seed_in,
`endif
    output logic [N-1:0] pattern_out,
    output logic         pattern_valid,
    input  logic         misr_done_in,
    output logic         misr_restart,
    output logic         busy,
    output logic         done,
    output logic         timeout_err
);

    localparam int PW = $clog2(NUM_PATTERNS) + 1;
    localparam int TW = $clog2(SIG_TIMEOUT) + 1;
    localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  SEED_FIX = (SEED == '0) ? ONE : SEED;
    localparam logic [PW-1:0] PAT_LAST = PW'(NUM_PATTERNS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(SIG_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT_SIG
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  lfsr, lfsr_n;
    logic [PW-1:0] pat_cnt, pat_cnt_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          timeout_n;
    logic [N-1:0]  run_seed;

    // Zero state would lock the Galois register forever, so it is forced to 1.
    function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] q, input logic [N-1:0] c);
        logic [N-1:0] r;
        if (q == '0)
            r = ONE;
        else
            r = {q[N-2:0], 1'b0} ^ (c & {N{q[N-1]}});
        return r;
    endfunction

`ifdef TPG_SEED_LOAD_EN
    assign run_seed = (seed_in == '0) ? ONE : seed_in;
`else
    assign run_seed = SEED_FIX;
`endif

    assign pattern_out = lfsr;

    always_comb begin
        state_n       = state;
        lfsr_n        = lfsr;
        pat_cnt_n     = pat_cnt;
        to_cnt_n      = to_cnt;
        timeout_n     = timeout_err;
        pattern_valid = 1'b0;
        misr_restart  = 1'b0;
        done          = 1'b0;
        busy          = (state == ST_RUN) || (state == ST_WAIT_SIG);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    lfsr_n    = run_seed;
                    pat_cnt_n = '0;
                    timeout_n = 1'b0;
                    state_n   = ST_RUN;
                end
            end
            ST_RUN: begin
                pattern_valid = ~hold;
                if (!hold) begin
                    pat_cnt_n = pat_cnt + 1'b1;
                    // The final pattern is not advanced past so it stays visible until the next start.
                    if (pat_cnt == PAT_LAST) begin
                        to_cnt_n = '0;
                        state_n  = ST_WAIT_SIG;
                    end else begin
                        lfsr_n = lfsr_step(lfsr, coeff);
                    end
                end
            end
            ST_WAIT_SIG: begin
                to_cnt_n = to_cnt + 1'b1;
                if (misr_done_in) begin
                    misr_restart = 1'b1;
                    done         = 1'b1;
                    state_n      = ST_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    misr_restart = 1'b1;
                    timeout_n    = 1'b1;
                    state_n      = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            lfsr        <= SEED_FIX;
            pat_cnt     <= '0;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            lfsr        <= lfsr_n;
            pat_cnt     <= pat_cnt_n;
            to_cnt      <= to_cnt_n;
            timeout_err <= timeout_n;
        end
    end

endmodule

// File: tb/tb_generic_lfsr_tpg.sv
// Bench for generic_lfsr_tpg with N=4, NUM_PATTERNS=8, SIG_TIMEOUT=4, SEED=1.
module tb_generic_lfsr_tpg;

    localparam int NP = 8;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] coeff = 4'd3;
    logic [3:0] seed_in = 4'd1;
    logic [3:0] pattern_out;
    logic       pattern_valid;
    logic       misr_done_in = 1'b0;
    logic       misr_restart;
    logic       busy;
    logic       done;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    logic [3:0] got[$];
    logic [3:0] exp1 [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b1011};

    generic_lfsr_tpg #(.N(4), .NUM_PATTERNS(NP), .SEED(4'd1), .SIG_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .coeff(coeff),
`ifdef TPG_SEED_LOAD_EN
        .seed_in(seed_in),
`endif
        .pattern_out(pattern_out), .pattern_valid(pattern_valid),
        .misr_done_in(misr_done_in), .misr_restart(misr_restart),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Multiply by x modulo the polynomial x^4 + coeff; zero state restarts at 1.
    function automatic logic [3:0] ref_next(input logic [3:0] q, input logic [3:0] c);
        int v;
        if (q == 4'd0) return 4'd1;
        v = (int'(q) * 2) % 16;
        if (q >= 4'd8) v = v ^ int'(c);
        return 4'(v);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input logic [3:0] c, input logic [3:0] sd, input logic [63:0] hv,
                          input int done_at, input bit rnd);
        logic [3:0] q;
        int cnt;
        int cyc;
        got.delete();
        coeff = c;
        seed_in = sd;
        start = 1'b1;
        hold = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        misr_done_in = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_valid", pattern_valid, 0);
        step();
        start = 1'b0;
`ifdef TPG_SEED_LOAD_EN
        q = (sd == 4'd0) ? 4'd1 : sd;
`else
        q = 4'd1;
`endif
        cnt = 0;
        cyc = 0;
        while (cnt < NP && cyc < 100) begin
            hold = hv[cyc % 64];
            start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            misr_done_in = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            chk("run_valid", pattern_valid, !hold);
            chk("run_pattern", pattern_out, q);
            chk("run_busy", busy, 1);
            chk("run_terr", timeout_err, 0);
            chk("run_done", done, 0);
            if (!hold) begin
                got.push_back(q);
                cnt++;
                if (cnt < NP) q = ref_next(q, c);
            end
            step();
            cyc++;
        end
        chk("run_bound", cnt, NP);
        for (int w = 1; w <= TO; w++) begin
            misr_done_in = (w == done_at);
            hold = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            chk("wait_valid", pattern_valid, 0);
            chk("wait_busy", busy, 1);
            chk("wait_done", done, (w == done_at));
            chk("wait_restart", misr_restart, (w == done_at) || (w == TO));
            chk("wait_pattern", pattern_out, q);
            step();
            if (w == done_at) break;
        end
        start = 1'b0;
        hold = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        misr_done_in = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_done", done, 0);
        chk("end_restart", misr_restart, 0);
        chk("end_valid", pattern_valid, 0);
        chk("end_terr", timeout_err, (done_at < 1) || (done_at > TO));
        chk("end_pattern", pattern_out, q);
        step();
        hold = 1'b0;
        misr_done_in = 1'b0;
    endtask

    initial begin
        step();
        step();
        @(negedge clk);
        chk("rst_pattern", pattern_out, 4'd1);
        chk("rst_valid", pattern_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_restart", misr_restart, 0);
        chk("rst_terr", timeout_err, 0);
        step();
        rst = 1'b0;

        // Basic sequence, done on 3rd wait cycle.
        do_run(4'b0011, 4'd1, 64'd0, 3, 1'b0);
        chk("seq_len", got.size(), NP);
        for (int i = 0; i < NP && i < got.size(); i++) chk("seq_val", got[i], exp1[i]);

        // Hold for three cycles after the second pattern.
        do_run(4'b0011, 4'd1, 64'h1C, 3, 1'b0);
        chk("hold_len", got.size(), NP);
        for (int i = 0; i < NP && i < got.size(); i++) chk("hold_val", got[i], exp1[i]);

        // Signature timeout.
        do_run(4'b0011, 4'd1, 64'd0, 0, 1'b0);

        // Reset while emitting pattern 5.
        coeff = 4'b0011;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        @(negedge clk);
        chk("prerst_pattern", pattern_out, 4'b0011);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_pattern", pattern_out, 4'd1);
        chk("midrst_valid", pattern_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_terr", timeout_err, 0);
        step();
        do_run(4'b0011, 4'd1, 64'd0, 2, 1'b0);
        chk("after_rst_first", got[0], 4'd1);

`ifdef TPG_SEED_LOAD_EN
        do_run(4'b0011, 4'b1001, 64'd0, 1, 1'b0);
        chk("seed_first", got[0], 4'b1001);
        chk("seed_second", got[1], 4'b0001);
        do_run(4'b0011, 4'd0, 64'd0, 1, 1'b0);
        chk("seed_zero_first", got[0], 4'b0001);
`endif

        for (int r = 0; r < 10; r++)
            do_run(4'($urandom), 4'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 5)), 1'b1);

        // Zero feedback polynomial drives the register into the lock-up guard.
        do_run(4'b0000, 4'd1, 64'd0, 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
